// File: rtl/debug_frame_serializer_pkg.sv
// Shared definitions for the pipeline debug-frame serializer: FSM states and snapshot field widths.
// Optional feature macro: DEBUG_FRAME_CHECKSUM_EN (see debug_frame_serializer.sv).
package debug_frame_serializer_pkg;

  localparam int NB_IF_ID  = 64;
  localparam int NB_ID_EX  = 168;
  localparam int NB_EX_MEM = 88;
  localparam int NB_MEM_WB = 80;

  localparam int NB_DATA_DEFAULT  = 8;
  localparam int NB_FRAME_DEFAULT = NB_IF_ID + NB_ID_EX + NB_EX_MEM + NB_MEM_WB;
  localparam int N_BYTES          = NB_FRAME_DEFAULT / NB_DATA_DEFAULT;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SEND  = 3'd1,
    WAIT  = 3'd2,
    CSUM  = 3'd3,
    CWAIT = 3'd4,
    DONE  = 3'd5
  } state_t;

  function automatic int calcNBytes(input int nbFrame, input int nbData);
    return nbFrame / nbData;
  endfunction

endpackage

// File: rtl/debug_frame_serializer.sv
// Streams a captured pipeline snapshot to uart_tx one NB_DATA-bit byte at a time, MSB byte first.
// Define DEBUG_FRAME_CHECKSUM_EN to append an XOR checksum byte after the payload.
module debug_frame_serializer
  import debug_frame_serializer_pkg::*;
#(
  parameter int NB_DATA  = NB_DATA_DEFAULT,
  parameter int NB_FRAME = NB_FRAME_DEFAULT
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic [NB_FRAME-1:0] i_frame,
  input  logic                i_start,
  input  logic                i_tx_done,
  output logic [NB_DATA-1:0]  o_tx_data,
  output logic                o_tx_start,
  output logic                o_busy,
  output logic                o_done
);

  localparam int N_BYTES_L = calcNBytes(NB_FRAME, NB_DATA);
  localparam int NB_CNT    = $clog2(N_BYTES_L) + 1;

  generate
    if ((NB_FRAME % NB_DATA) != 0) begin : g_bad_frame_width
      $error("debug_frame_serializer: NB_FRAME must be a multiple of NB_DATA");
    end
  endgenerate

  state_t              r_state;
  state_t              w_next;
  logic [NB_FRAME-1:0] r_shift;
  logic [NB_CNT-1:0]   r_count;
  logic                w_last;
  logic [NB_DATA-1:0]  w_top;

  assign w_top  = r_shift[NB_FRAME-1 -: NB_DATA];
  assign w_last = (r_count == NB_CNT'(N_BYTES_L - 1));

`ifdef DEBUG_FRAME_CHECKSUM_EN
  logic [NB_DATA-1:0] r_csum;
`endif

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:  if (i_start) w_next = SEND;
      SEND:  w_next = WAIT;
      WAIT: begin
        if (i_tx_done) begin
`ifdef DEBUG_FRAME_CHECKSUM_EN
          w_next = w_last ? CSUM : SEND;
`else
          w_next = w_last ? DONE : SEND;
`endif
        end
      end
`ifdef DEBUG_FRAME_CHECKSUM_EN
      CSUM:  w_next = CWAIT;
      CWAIT: if (i_tx_done) w_next = DONE;
`endif
      DONE:  w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // The snapshot is captured once on an accepted start, so later i_frame changes cannot leak in.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_state <= IDLE;
      r_shift <= '0;
      r_count <= '0;
`ifdef DEBUG_FRAME_CHECKSUM_EN
      r_csum  <= '0;
`endif
    end else begin
      r_state <= w_next;
      case (r_state)
        IDLE: begin
          if (i_start) begin
            r_shift <= i_frame;
            r_count <= '0;
`ifdef DEBUG_FRAME_CHECKSUM_EN
            r_csum  <= '0;
`endif
          end
        end
`ifdef DEBUG_FRAME_CHECKSUM_EN
        SEND: r_csum <= r_csum ^ w_top;
`endif
        WAIT: begin
          if (i_tx_done) begin
            r_shift <= r_shift << NB_DATA;
            r_count <= r_count + NB_CNT'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign o_busy = (r_state != IDLE);
  assign o_done = (r_state == DONE);

`ifdef DEBUG_FRAME_CHECKSUM_EN
  assign o_tx_start = (r_state == SEND) || (r_state == CSUM);
  assign o_tx_data  = ((r_state == CSUM) || (r_state == CWAIT)) ? r_csum : w_top;
`else
  assign o_tx_start = (r_state == SEND);
  assign o_tx_data  = w_top;
`endif

endmodule

// File: tb/tb_debug_frame_serializer.sv
// Scoreboard bench: instance A uses a 24-bit frame, instance B the default 400-bit frame.
// Honours DEBUG_FRAME_CHECKSUM_EN by expecting the extra XOR byte when it is defined.
module tb_debug_frame_serializer;

  localparam int NBF_A = 24;
  localparam int NBF_B = 400;
`ifdef DEBUG_FRAME_CHECKSUM_EN
  localparam bit CSUM_ON = 1'b1;
`else
  localparam bit CSUM_ON = 1'b0;
`endif
  localparam int N_EXP_A = 3 + (CSUM_ON ? 1 : 0);
  localparam int N_EXP_B = 50 + (CSUM_ON ? 1 : 0);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rstA = 1'b0, startA = 1'b0, spurA = 1'b0;
  logic [NBF_A-1:0] frameA = '0;
  logic             txDoneA, txStartA, busyA, oDoneA;
  logic [7:0]       dataA;
  int               cntA = 0;

  logic             rstB = 1'b0, startB = 1'b0;
  logic [NBF_B-1:0] frameB = '0;
  logic             txDoneB, txStartB, busyB, oDoneB;
  logic [7:0]       dataB;
  int               cntB = 0;

  debug_frame_serializer #(.NB_DATA(8), .NB_FRAME(NBF_A)) dutA (
    .i_clk(clk), .i_reset(rstA), .i_frame(frameA), .i_start(startA), .i_tx_done(txDoneA),
    .o_tx_data(dataA), .o_tx_start(txStartA), .o_busy(busyA), .o_done(oDoneA));

  debug_frame_serializer dutB (
    .i_clk(clk), .i_reset(rstB), .i_frame(frameB), .i_start(startB), .i_tx_done(txDoneB),
    .o_tx_data(dataB), .o_tx_start(txStartB), .o_busy(busyB), .o_done(oDoneB));

  // uart_tx model: byte-complete pulse 10 cycles after each tx_start
  always @(posedge clk) begin
    if (!rstA) cntA <= 0;
    else if (txStartA) cntA <= 10;
    else if (cntA != 0) cntA <= cntA - 1;
    if (!rstB) cntB <= 0;
    else if (txStartB) cntB <= 10;
    else if (cntB != 0) cntB <= cntB - 1;
  end
  assign txDoneA = (cntA == 1) || spurA;
  assign txDoneB = (cntB == 1);

  int checks = 0, failures = 0;
  logic [7:0] expA[$];
  logic [7:0] expB[$];
  int bytesA = 0, bytesB = 0, doneCntA = 0, doneCntB = 0;
  logic prevStartA = 1'b0, prevStartB = 1'b0;

  task automatic checkOutput(input string name, input longint unsigned act, input longint unsigned exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitors: pop expected bytes whenever a DUT issues tx_start
  always @(negedge clk) begin
    if (txStartA) begin
      checkOutput("startWidthA", prevStartA, 0);
      if (expA.size() == 0) checkOutput("unexpectedByteA", dataA, 256);
      else checkOutput("byteA", dataA, expA.pop_front());
      bytesA++;
    end
    if (oDoneA) begin
      checkOutput("doneWithPendingA", expA.size(), 0);
      doneCntA++;
    end
    prevStartA = txStartA;
  end

  always @(negedge clk) begin
    if (txStartB) begin
      checkOutput("startWidthB", prevStartB, 0);
      if (expB.size() == 0) checkOutput("unexpectedByteB", dataB, 256);
      else checkOutput("byteB", dataB, expB.pop_front());
      bytesB++;
    end
    if (oDoneB) begin
      checkOutput("doneWithPendingB", expB.size(), 0);
      doneCntB++;
    end
    prevStartB = txStartB;
  end

  task automatic applyStimulus(input logic [NBF_A-1:0] f, input bit spurInSend);
    logic [7:0] b;
    logic [7:0] x;
    x = '0;
    for (int i = NBF_A/8 - 1; i >= 0; i--) begin
      b = f[i*8 +: 8];
      expA.push_back(b);
      x = x ^ b;
    end
    if (CSUM_ON) expA.push_back(x);
    frameA = f;
    startA = 1'b1;
    @(negedge clk);
    startA = 1'b0;
    if (spurInSend) spurA = 1'b1;
    @(negedge clk);
    spurA = 1'b0;
  endtask

  task automatic waitDoneA(input bit pulseStartOnDone);
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (oDoneA) break;
    end
    checkOutput("doneSeenA", oDoneA, 1);
    if (pulseStartOnDone && oDoneA) begin
      startA = 1'b1;
      @(negedge clk);
      startA = 1'b0;
    end
  endtask

  initial begin
    int b0, d0;
    logic [7:0] x;
    logic busyDrop;

    repeat (4) @(negedge clk);
    checkOutput("rstDataA", dataA, 0);
    checkOutput("rstStartA", txStartA, 0);
    checkOutput("rstBusyA", busyA, 0);
    checkOutput("rstDoneA", oDoneA, 0);
    checkOutput("rstBusyB", busyB, 0);
    rstA = 1'b1;
    rstB = 1'b1;
    repeat (2) @(negedge clk);

    $display("[TB] spurious tx_done in IDLE");
    spurA = 1'b1;
    @(negedge clk);
    spurA = 1'b0;
    repeat (4) @(negedge clk);
    checkOutput("idleSpuriousBusyA", busyA, 0);
    checkOutput("idleSpuriousBytesA", bytesA, 0);

    $display("[TB] frame A1B2C3");
    b0 = bytesA; d0 = doneCntA;
    applyStimulus(24'hA1B2C3, 1'b0);
    waitDoneA(1'b0);
    @(negedge clk);
    checkOutput("busyAfterDoneA", busyA, 0);
    checkOutput("byteCountA1", bytesA - b0, N_EXP_A);
    checkOutput("doneCountA1", doneCntA - d0, 1);

    $display("[TB] spurious tx_done in SEND");
    b0 = bytesA; d0 = doneCntA;
    applyStimulus(24'h123456, 1'b1);
    waitDoneA(1'b0);
    @(negedge clk);
    checkOutput("byteCountA2", bytesA - b0, N_EXP_A);
    checkOutput("doneCountA2", doneCntA - d0, 1);

    $display("[TB] start during WAIT and DONE, frame change after capture");
    b0 = bytesA; d0 = doneCntA;
    applyStimulus(24'h0F55F0, 1'b0);
    repeat (4) @(negedge clk);
    startA = 1'b1;
    frameA = 24'hFFFFFF;
    @(negedge clk);
    startA = 1'b0;
    waitDoneA(1'b1);
    repeat (40) @(negedge clk);
    checkOutput("byteCountA3", bytesA - b0, N_EXP_A);
    checkOutput("doneCountA3", doneCntA - d0, 1);
    checkOutput("idleAfterIgnoredStartA", busyA, 0);

    $display("[TB] reset mid-dump");
    b0 = bytesA; d0 = doneCntA;
    applyStimulus(24'h5A6B7C, 1'b0);
    repeat (12) @(negedge clk);
    checkOutput("midDumpBusyA", busyA, 1);
    rstA = 1'b0;
    expA.delete();
    @(negedge clk);
    checkOutput("abortDataA", dataA, 0);
    checkOutput("abortStartA", txStartA, 0);
    checkOutput("abortBusyA", busyA, 0);
    checkOutput("abortDoneA", oDoneA, 0);
    repeat (2) @(negedge clk);
    rstA = 1'b1;
    repeat (60) @(negedge clk);
    checkOutput("abortByteCountA", bytesA - b0, 2);
    checkOutput("abortDoneCountA", doneCntA - d0, 0);

    $display("[TB] 400-bit frame");
    x = '0;
    for (int i = 0; i < 50; i++) frameB[i*8 +: 8] = 8'($urandom_range(0, 255));
    for (int i = 49; i >= 0; i--) begin
      expB.push_back(frameB[i*8 +: 8]);
      x = x ^ frameB[i*8 +: 8];
    end
    if (CSUM_ON) expB.push_back(x);
    startB = 1'b1;
    @(negedge clk);
    startB = 1'b0;
    busyDrop = 1'b0;
    for (int k = 0; k < 1200; k++) begin
      if (oDoneB) break;
      if (!busyB) busyDrop = 1'b1;
      @(negedge clk);
    end
    checkOutput("doneSeenB", oDoneB, 1);
    checkOutput("busyHeldB", busyDrop, 0);
    @(negedge clk);
    checkOutput("byteCountB", bytesB, N_EXP_B);
    checkOutput("doneCountB", doneCntB, 1);
    checkOutput("busyAfterDoneB", busyB, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
